// File: rtl/collision_monitor_pkg.sv
// Shared game constants and the collision monitor state encoding.
package collision_monitor_pkg;

  localparam int MAX_X        = 640;
  localparam int MAX_Y        = 480;
  localparam int SPRITE_W_DEF = 16;
  localparam int SPRITE_H_DEF = 16;

  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    INVULN    = 2'd1,
    GAME_OVER = 2'd2
  } state_t;

endpackage

// File: rtl/collision_monitor_if.sv
// Sprite inputs and game-status outputs of the collision monitor.
interface collision_monitor_if;
  logic        frame_tick;
  logic        game_restart;
  logic [9:0]  yoshi_x;
  logic [9:0]  yoshi_y;
  logic [9:0]  obst_x;
  logic [9:0]  obst_y;
  logic        yoshi_on;
  logic        obst_on;
  logic        hit_pulse;
  logic [2:0]  lives;
  logic        invuln;
  logic        blink;
  logic        game_over;
  logic [15:0] frames_survived;

  // Drives the sprite/timing inputs and observes the status outputs.
  modport master (
    output frame_tick, game_restart, yoshi_x, yoshi_y, obst_x, obst_y, yoshi_on, obst_on,
    input  hit_pulse, lives, invuln, blink, game_over, frames_survived
  );

  // The monitor itself.
  modport slave (
    input  frame_tick, game_restart, yoshi_x, yoshi_y, obst_x, obst_y, yoshi_on, obst_on,
    output hit_pulse, lives, invuln, blink, game_over, frames_survived
  );
endinterface

// File: rtl/collision_monitor_bbox_overlap.sv
// bbox_overlap: combinational rectangle-overlap test for two equal-size sprites.
// Sums are done in 11 bits so positions near 1023 cannot wrap to a false overlap.
module collision_monitor_bbox_overlap
  import collision_monitor_pkg::*;
#(
  parameter int W = SPRITE_W_DEF,
  parameter int H = SPRITE_H_DEF
) (
  input  logic [9:0] ax,
  input  logic [9:0] ay,
  input  logic [9:0] bx,
  input  logic [9:0] by,
  output logic       overlap
);
  localparam logic [10:0] W11 = 11'(W);
  localparam logic [10:0] H11 = 11'(H);

  logic [10:0] ax_e, ay_e, bx_e, by_e;
  logic        x_ovl, y_ovl;

  assign ax_e = {1'b0, ax};
  assign ay_e = {1'b0, ay};
  assign bx_e = {1'b0, bx};
  assign by_e = {1'b0, by};

  // Overlap on each axis independently; rectangles touch only if both overlap.
  assign x_ovl   = (ax_e < bx_e + W11) && (bx_e < ax_e + W11);
  assign y_ovl   = (ay_e < by_e + H11) && (by_e < ay_e + H11);
  assign overlap = x_ovl && y_ovl;
endmodule

// File: rtl/collision_monitor.sv
// Per-frame yoshi/obstacle contact detection with lives, invulnerability
// window and game-over handling. All outputs come straight from registers.
module collision_monitor
  import collision_monitor_pkg::*;
#(
  parameter int SPRITE_W      = SPRITE_W_DEF,
  parameter int SPRITE_H      = SPRITE_H_DEF,
  parameter int LIVES         = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int USE_BBOX      = 1
) (
  input  logic                clk,
  input  logic                reset,
  collision_monitor_if.slave  bus
);
  state_t      state_reg, state_next;
  logic [2:0]  lives_reg, lives_next;
  logic [7:0]  inv_cnt_reg, inv_cnt_next;
  logic        overlap_reg, overlap_next;
  logic [15:0] frames_reg, frames_next;
  logic        hit_reg, hit_next;
  logic        invuln_reg, invuln_next;
  logic        blink_reg, blink_next;
  logic        game_over_reg, game_over_next;

  logic        pix_overlap;
  logic        bbox_hit;
  logic        collision;

  assign pix_overlap = bus.yoshi_on & bus.obst_on;

  generate
    if (USE_BBOX != 0) begin : g_bbox
      collision_monitor_bbox_overlap #(
        .W (SPRITE_W),
        .H (SPRITE_H)
      ) u_bbox (
        .ax      (bus.yoshi_x),
        .ay      (bus.yoshi_y),
        .bx      (bus.obst_x),
        .by      (bus.obst_y),
        .overlap (bbox_hit)
      );
    end else begin : g_no_bbox
      assign bbox_hit = 1'b0;
    end
  endgenerate

  // A pixel overlap in the tick cycle itself still belongs to the closing frame.
  assign collision = overlap_reg | pix_overlap | bbox_hit;

  // Next-state logic: restart wins over frame_tick; frame decisions only on frame_tick.
  always_comb begin
    state_next   = state_reg;
    lives_next   = lives_reg;
    inv_cnt_next = inv_cnt_reg;
    frames_next  = frames_reg;
    hit_next     = 1'b0;
    overlap_next = overlap_reg | pix_overlap;

    if (bus.game_restart) begin
      state_next   = PLAY;
      lives_next   = 3'(LIVES);
      overlap_next = 1'b0;
      frames_next  = 16'd0;
      inv_cnt_next = 8'd0;
    end else if (bus.frame_tick) begin
      overlap_next = 1'b0;
      if (state_reg != GAME_OVER && frames_reg != 16'hFFFF)
        frames_next = frames_reg + 16'd1;
      case (state_reg)
        PLAY: begin
          if (collision) begin
            hit_next = 1'b1;
            if (lives_reg > 3'd1) begin
              lives_next   = lives_reg - 3'd1;
              inv_cnt_next = 8'(INVULN_FRAMES - 1);
              state_next   = INVULN;
            end else begin
              lives_next = 3'd0;
              state_next = GAME_OVER;
            end
          end
        end
        INVULN: begin
          if (inv_cnt_reg == 8'd0)
            state_next = PLAY;
          else
            inv_cnt_next = inv_cnt_reg - 8'd1;
        end
        default: ;
      endcase
    end

    invuln_next    = (state_next == INVULN);
    game_over_next = (state_next == GAME_OVER);
    blink_next     = (state_next == INVULN) ? ~inv_cnt_next[2] : 1'b1;
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= PLAY;
      lives_reg     <= 3'(LIVES);
      inv_cnt_reg   <= 8'd0;
      overlap_reg   <= 1'b0;
      frames_reg    <= 16'd0;
      hit_reg       <= 1'b0;
      invuln_reg    <= 1'b0;
      blink_reg     <= 1'b1;
      game_over_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      lives_reg     <= lives_next;
      inv_cnt_reg   <= inv_cnt_next;
      overlap_reg   <= overlap_next;
      frames_reg    <= frames_next;
      hit_reg       <= hit_next;
      invuln_reg    <= invuln_next;
      blink_reg     <= blink_next;
      game_over_reg <= game_over_next;
    end
  end

  assign bus.hit_pulse       = hit_reg;
  assign bus.lives           = lives_reg;
  assign bus.invuln          = invuln_reg;
  assign bus.blink           = blink_reg;
  assign bus.game_over       = game_over_reg;
  assign bus.frames_survived = frames_reg;
endmodule

// File: tb/tb_collision_monitor.sv
// Scoreboard bench: two monitors (bbox on / bbox off) share one stimulus stream.
// Expected status after each frame_tick/restart/reset is queued by the stimulus
// and checked by independent monitor processes.
module tb_collision_monitor;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  collision_monitor_if if1 ();
  collision_monitor_if if0 ();

  assign if0.frame_tick   = if1.frame_tick;
  assign if0.game_restart = if1.game_restart;
  assign if0.yoshi_x      = if1.yoshi_x;
  assign if0.yoshi_y      = if1.yoshi_y;
  assign if0.obst_x       = if1.obst_x;
  assign if0.obst_y       = if1.obst_y;
  assign if0.yoshi_on     = if1.yoshi_on;
  assign if0.obst_on      = if1.obst_on;

  collision_monitor #(.USE_BBOX(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  collision_monitor #(.USE_BBOX(0)) dut0 (.clk(clk), .reset(reset), .bus(if0));

  typedef struct {
    logic        hit1;
    logic [2:0]  lives1;
    logic        inv1;
    logic        blink1;
    logic        go1;
    logic [15:0] fr1;
    logic        hit0;
    logic [2:0]  lives0;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_ev  = 0;
  logic ev_d  = 1'b0;

  function automatic exp_t mk(input logic h1, input int l1, input logic i1, input logic b1,
                              input logic g1, input int f1, input logic h0, input int l0);
    exp_t e;
    e.hit1 = h1; e.lives1 = 3'(l1); e.inv1 = i1; e.blink1 = b1;
    e.go1 = g1; e.fr1 = 16'(f1); e.hit0 = h0; e.lives0 = 3'(l0);
    return e;
  endfunction

  // Expected blink/invuln after the i-th tick of a 60-frame invulnerability window.
  function automatic logic inv_at(input int i);
    return (i < 60);
  endfunction
  function automatic logic blink_at(input int i);
    int c;
    c = 59 - i;
    if (i >= 60) return 1'b1;
    return ~c[2];
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s event %0d: got %0h want %0h", nm, n_ev, act, req);
    end
  endtask

  task automatic compare_all(input exp_t e);
    chk("hit1",    16'(if1.hit_pulse),   16'(e.hit1));
    chk("lives1",  16'(if1.lives),       16'(e.lives1));
    chk("invuln1", 16'(if1.invuln),      16'(e.inv1));
    chk("blink1",  16'(if1.blink),       16'(e.blink1));
    chk("gover1",  16'(if1.game_over),   16'(e.go1));
    chk("frames1", if1.frames_survived,  e.fr1);
    chk("hit0",    16'(if0.hit_pulse),   16'(e.hit0));
    chk("lives0",  16'(if0.lives),       16'(e.lives0));
    $display("event %0d: hit=%0b/%0b lives=%0d/%0d inv=%0b blink=%0b go=%0b frames=%0d",
             n_ev, if1.hit_pulse, if0.hit_pulse, if1.lives, if0.lives,
             if1.invuln, if1.blink, if1.game_over, if1.frames_survived);
    n_ev++;
  endtask

  // Remember whether the last clock edge carried a decision-triggering input.
  always @(posedge clk) ev_d <= if1.frame_tick | if1.game_restart;

  // Decision results appear one cycle after tick/restart; otherwise hit must stay low.
  always @(negedge clk) begin
    if (ev_d) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL scoreboard: output event with empty queue");
      end else begin
        compare_all(exp_q.pop_front());
      end
    end else if (!reset) begin
      chk("idle_hit1", 16'(if1.hit_pulse), 16'd0);
      chk("idle_hit0", 16'(if0.hit_pulse), 16'd0);
    end
  end

  // Asynchronous reset must take effect without waiting for a clock.
  always @(posedge reset) begin
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard: reset with empty queue");
    end else begin
      compare_all(exp_q.pop_front());
    end
  end

  task automatic do_ev(input bit tick, input bit restart, input bit pix_now, input bit pix_after,
                       input exp_t e);
    @(negedge clk);
    exp_q.push_back(e);
    if1.frame_tick = tick; if1.game_restart = restart;
    if1.yoshi_on = pix_now; if1.obst_on = pix_now;
    @(negedge clk);
    if1.frame_tick = 1'b0; if1.game_restart = 1'b0;
    if1.yoshi_on = pix_after; if1.obst_on = pix_after;
    @(negedge clk);
    if1.yoshi_on = 1'b0; if1.obst_on = 1'b0;
  endtask

  task automatic set_obst(input int x, input int y);
    if1.obst_x = 10'(x); if1.obst_y = 10'(y);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    if1.frame_tick = 1'b0; if1.game_restart = 1'b0;
    if1.yoshi_on = 1'b0; if1.obst_on = 1'b0;
    if1.yoshi_x = 10'd100; if1.yoshi_y = 10'd100;
    set_obst(400, 300);

    // Power-on reset values.
    exp_q.push_back(mk(0, 3, 0, 1, 0, 0, 0, 3));
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Three quiet frames.
    for (int k = 1; k <= 3; k++) do_ev(1, 0, 0, 0, mk(0, 3, 0, 1, 0, k, 0, 3));

    // Bounding boxes overlap: only the bbox-enabled monitor takes a hit.
    set_obst(110, 105);
    do_ev(1, 0, 0, 0, mk(1, 2, 1, 1, 0, 4, 0, 3));

    // Overlap held through the whole invulnerability window.
    for (int i = 1; i <= 60; i++)
      do_ev(1, 0, 0, 0, mk(0, 2, inv_at(i), blink_at(i), 0, 4 + i, 0, 3));
    do_ev(1, 0, 0, 0, mk(1, 1, 1, 1, 0, 65, 0, 3));

    // Let the second window expire with no contact.
    set_obst(400, 300);
    for (int i = 1; i <= 60; i++)
      do_ev(1, 0, 0, 0, mk(0, 1, inv_at(i), blink_at(i), 0, 65 + i, 0, 3));

    // Single-cycle pixel overlap coincident with frame_tick: both monitors hit,
    // last life gone on the bbox monitor.
    do_ev(1, 0, 1, 0, mk(1, 0, 0, 1, 1, 126, 1, 2));

    // Game over: overlapping frames count nothing and frames freeze. A pixel
    // pulse in the frame before the window ends must be discarded at that tick.
    set_obst(110, 105);
    for (int i = 1; i <= 60; i++)
      do_ev(1, 0, (i % 10) == 0, i == 59, mk(0, 0, 0, 1, 1, 126, 0, 2));

    // Clean frame, then a pixel pulse just after the tick is counted next frame.
    do_ev(1, 0, 0, 1, mk(0, 0, 0, 1, 1, 126, 0, 2));
    do_ev(1, 0, 0, 0, mk(0, 0, 0, 1, 1, 126, 1, 1));

    // Restart alone, then restart coincident with a colliding tick.
    do_ev(0, 1, 0, 0, mk(0, 3, 0, 1, 0, 0, 0, 3));
    do_ev(1, 1, 1, 0, mk(0, 3, 0, 1, 0, 0, 0, 3));
    do_ev(1, 0, 0, 0, mk(1, 2, 1, 1, 0, 1, 0, 3));

    // Asynchronous reset in the middle of invulnerability.
    repeat (2) @(negedge clk);
    exp_q.push_back(mk(0, 3, 0, 1, 0, 0, 0, 3));
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    set_obst(400, 300);
    do_ev(1, 0, 0, 0, mk(0, 3, 0, 1, 0, 1, 0, 3));

    repeat (4) @(negedge clk);
    chk("queue_left", 16'(exp_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/collision_monitor.md
Name: collision_monitor

Overview:
- Consumer of sprite position/on signals produced by the obstacle sprite blocks (shark, ghost) and the yoshi sprite block.
- Detects yoshi–obstacle contact once per video frame and runs a lives / invulnerability / game-over state machine.
- Outputs drive the yoshi blink effect, the HUD lives counter and the top-level game FSM.

Parameters:
- SPRITE_W, 16, sprite width in pixels (yoshi and obstacle)
- SPRITE_H, 16, sprite height in pixels
- LIVES, 3, lives loaded at reset/restart (1..7)
- INVULN_FRAMES, 60, frames of invulnerability after a non-fatal hit (1..255)
- USE_BBOX, 1, 1 = also evaluate bounding-box overlap at frame end

Ports:
- clk  in  1  pixel/system clock
- reset  in  1  asynchronous, active-high
- frame_tick  in  1  one-cycle pulse at start of vertical blank (end of visible frame)
- game_restart  in  1  one-cycle synchronous pulse; restarts game from any state
- yoshi_x, yoshi_y  in  10 each  yoshi top-left pixel position
- obst_x, obst_y  in  10 each  obstacle top-left pixel position
- yoshi_on  in  1  current VGA pixel lies inside yoshi sprite
- obst_on  in  1  current VGA pixel lies inside obstacle sprite
- hit_pulse  out  1  one-cycle pulse when a counted hit occurs
- lives  out  3  remaining lives
- invuln  out  1  high while in INVULN
- blink  out  1  yoshi blink enable (low = hide yoshi)
- game_over  out  1  high while in GAME_OVER
- frames_survived  out  16  saturating frame counter

Behaviour:
- Reset is async (reset as decided above). On reset: state=PLAY, lives=LIVES, hit_pulse=0, invuln=0, blink=1, game_over=0, frames_survived=0, overlap_flag=0, inv_cnt=0.
- overlap_flag: set on any clk cycle where yoshi_on & obst_on.
  - Cleared on every frame_tick cycle, in all states.
  - If overlap and frame_tick occur in the same cycle, that overlap counts toward the closing frame.
- bbox term, evaluated with 11-bit zero-extended sums (no 10-bit wrap):
  - yoshi_x < obst_x+SPRITE_W and obst_x < yoshi_x+SPRITE_W
  - yoshi_y < obst_y+SPRITE_H and obst_y < yoshi_y+SPRITE_H
  - Forced 0 when USE_BBOX=0.
- collision = overlap_flag | (yoshi_on & obst_on) | bbox. Sampled only on frame_tick cycles.
- All outputs are registered. Decisions taken on a frame_tick cycle are visible on the following cycle (latency 1).
- FSM transitions (on frame_tick unless noted):
  - PLAY, collision, lives>1: lives-=1, inv_cnt=INVULN_FRAMES-1, go INVULN, hit_pulse=1 for one cycle.
  - PLAY, collision, lives==1: lives=0, go GAME_OVER, hit_pulse=1 for one cycle.
  - PLAY, no collision: stay.
  - INVULN: collision ignored, no hit_pulse. If inv_cnt==0 go PLAY, else inv_cnt-=1.
  - GAME_OVER: frame_tick ignored. Lives hold at 0.
- game_restart, any state, synchronous: state=PLAY, lives=LIVES, overlap_flag=0, frames_survived=0, inv_cnt=0.
  - Takes priority over a coincident frame_tick; that frame is not evaluated.
- invuln = (state==INVULN). game_over = (state==GAME_OVER).
- blink = 1 outside INVULN; inside INVULN, blink = ~inv_cnt[2] (toggles every 4 frames).
- frames_survived: +1 on frame_tick in PLAY/INVULN. Saturates at 16'hFFFF. Holds in GAME_OVER.
- Lives never underflow. No hit is counted in GAME_OVER.

Decomposition:
- Shared game package: MAX_X=640, MAX_Y=480, SPRITE_W/H defaults, state encoding localparams (PLAY=2'd0, INVULN=2'd1, GAME_OVER=2'd2).
- One natural sub-module: bbox_overlap, a combinational 11-bit rectangle compare reused by other obstacle monitors.
- FSM, flag, lives and counters stay in collision_monitor.

Test Plan:
- Reset then 3 frame_ticks, no overlap -> lives=3, state PLAY, frames_survived=3, hit_pulse never high.
- Yoshi (100,100), obstacle (110,105), USE_BBOX=1, frame_tick -> next cycle hit_pulse=1 for 1 cycle, lives=2, invuln=1, blink follows inv_cnt.
- Keep overlap during INVULN for 60 frame_ticks -> no further hits, lives=2; after 60th tick invuln=0. Next tick with overlap -> lives=1.
- USE_BBOX=0, single-cycle yoshi_on&obst_on pulse coincident with frame_tick -> hit counted. Overlap pulse one cycle after frame_tick -> counted at the next frame.
- Three hits separated by expired invulnerability -> lives=0, game_over=1. Further overlapping frames -> no hit_pulse, frames_survived frozen.
- game_restart coincident with a colliding frame_tick in PLAY -> lives=3, no hit_pulse. Async reset asserted mid-INVULN -> outputs return to reset values immediately.
